// File: rtl/iir_biquad_mc_pkg.sv
// Shared definitions for the time-multiplexed biquad: FSM states, sequencing
// constants and the rounding-constant helper.
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WB,
    DONE
  } state_t;

  localparam int unsigned MAC_STEPS  = 5;
  localparam int unsigned CYC_PER_CH = MAC_STEPS + 1;

  // Half an LSB of the output, added before the arithmetic shift (round-half-up).
  function automatic longint unsigned rnd_const(input int unsigned scale);
    return (scale == 0) ? 64'd0 : (64'd1 << (scale - 1));
  endfunction

endpackage

// File: rtl/iir_biquad_mc_mac.sv
// Shared signed multiplier with accumulator for the biquad sequencer.
// Priority: clear, then load rounding constant, then accumulate/subtract.
module iir_mac
  import iir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 18,
  parameter int unsigned ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 3,
  parameter int unsigned COEFF_SCALE = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   load_rnd_i,
  input  logic                   en_i,
  input  logic                   sub_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [COEFF_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]   acc_o
);

  localparam int unsigned PW = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [ACC_WIDTH-1:0] RND = ACC_WIDTH'(rnd_const(COEFF_SCALE));

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_rnd_i) begin
      acc_d = RND;
    end else if (en_i) begin
      acc_d = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel biquad IIR sharing one multiplier across channels and terms.
// Define IIR_BIQUAD_SATURATE_EN to clamp results instead of legacy wrap.
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 18,
  parameter int unsigned COEFF_SCALE = 14,
  parameter int unsigned COUNT_BITS  = 10,
  parameter int unsigned ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [COUNT_BITS-1:0]          div,
  input  logic [COEFF_WIDTH-1:0]         A2,
  input  logic [COEFF_WIDTH-1:0]         A3,
  input  logic [COEFF_WIDTH-1:0]         B1,
  input  logic [COEFF_WIDTH-1:0]         B2,
  input  logic [COEFF_WIDTH-1:0]         B3,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in,
  output logic [CHANNELS*DATA_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic                           overrun
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ST_W = 3;

  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ST_W-1:0]       step_q, step_d;
  logic [COUNT_BITS-1:0] count_q;
  logic                  tick;

  logic [DATA_WIDTH-1:0] x0_q [CHANNELS];
  logic [DATA_WIDTH-1:0] x1_q [CHANNELS];
  logic [DATA_WIDTH-1:0] x2_q [CHANNELS];
  logic [DATA_WIDTH-1:0] y1_q [CHANNELS];
  logic [DATA_WIDTH-1:0] y2_q [CHANNELS];
  logic [DATA_WIDTH-1:0] stage_q [CHANNELS];

  logic [CHANNELS*DATA_WIDTH-1:0] out_q;
  logic                           valid_q;
  logic                           ovr_q;

  logic                    capture, wb_en, done_en;
  logic                    mac_clr, mac_load, mac_en, mac_sub;
  logic [DATA_WIDTH-1:0]   mac_a;
  logic [COEFF_WIDTH-1:0]  mac_b;
  logic [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]   y_nar;

  // div=0 makes div-1 all ones, giving the full 2^COUNT_BITS period.
  assign tick = (count_q == (div - COUNT_BITS'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + COUNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    step_d   = step_q;
    capture  = 1'b0;
    wb_en    = 1'b0;
    done_en  = 1'b0;
    mac_clr  = 1'b0;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    mac_sub  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          capture  = 1'b1;
          mac_load = 1'b1;
          ch_d     = '0;
          step_d   = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        mac_en  = 1'b1;
        mac_sub = (step_q >= ST_W'(3));
        if (step_q == ST_W'(MAC_STEPS - 1)) begin
          step_d  = '0;
          state_d = WB;
        end else begin
          step_d = step_q + ST_W'(1);
        end
      end
      WB: begin
        wb_en    = 1'b1;
        mac_load = 1'b1;
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = MAC;
        end
      end
      DONE: begin
        done_en = 1'b1;
        mac_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Term order per channel: B1x0, B2x1, B3x2, then subtract A2y1, A3y2.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    case (step_q)
      3'd0: begin mac_a = x0_q[ch_q]; mac_b = B1; end
      3'd1: begin mac_a = x1_q[ch_q]; mac_b = B2; end
      3'd2: begin mac_a = x2_q[ch_q]; mac_b = B3; end
      3'd3: begin mac_a = y1_q[ch_q]; mac_b = A2; end
      3'd4: begin mac_a = y2_q[ch_q]; mac_b = A3; end
      default: begin mac_a = '0; mac_b = '0; end
    endcase
  end

  iir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .COEFF_SCALE(COEFF_SCALE)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (mac_clr),
    .load_rnd_i(mac_load),
    .en_i      (mac_en),
    .sub_i     (mac_sub),
    .a_i       (mac_a),
    .b_i       (mac_b),
    .acc_o     (acc)
  );

  assign shifted = $signed(acc) >>> COEFF_SCALE;

`ifdef IIR_BIQUAD_SATURATE_EN
  always_comb begin
    y_nar = shifted[DATA_WIDTH-1:0];
    if (shifted > Y_MAX) begin
      y_nar = Y_MAX[DATA_WIDTH-1:0];
    end else if (shifted < Y_MIN) begin
      y_nar = Y_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  logic unused_hi;
  logic unused_lim;
  assign y_nar      = {shifted[ACC_WIDTH-1], shifted[DATA_WIDTH-2:0]};
  assign unused_hi  = ^shifted[ACC_WIDTH-2:DATA_WIDTH-1];
  assign unused_lim = ^{Y_MAX, Y_MIN};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        x0_q[i]    <= '0;
        x1_q[i]    <= '0;
        x2_q[i]    <= '0;
        y1_q[i]    <= '0;
        y2_q[i]    <= '0;
        stage_q[i] <= '0;
      end
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= done_en;
      if (tick && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end
      if (capture) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          x0_q[i] <= in[i*DATA_WIDTH +: DATA_WIDTH];
          x1_q[i] <= x0_q[i];
          x2_q[i] <= x1_q[i];
        end
      end
      if (wb_en) begin
        y1_q[ch_q]    <= y_nar;
        y2_q[ch_q]    <= y1_q[ch_q];
        stage_q[ch_q] <= y_nar;
      end
      if (done_en) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          out_q[i*DATA_WIDTH +: DATA_WIDTH] <= stage_q[i];
        end
      end
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Self-checking bench for iir_biquad_mc: directed scenarios plus random
// coefficient/input frames checked against a difference-equation model.
module tb_iir_biquad_mc;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int CW = 18;
  localparam int CS = 14;
  localparam int CB = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [CB-1:0]     div;
  logic [CW-1:0]     A2, A3, B1, B2, B3;
  logic [CH*DW-1:0]  in_bus;
  logic [CH*DW-1:0]  out_bus;
  logic              out_valid;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  longint cur_in [CH];
  longint hx0 [CH], hx1 [CH], hx2 [CH], hy1 [CH], hy2 [CH];
  longint expv [CH];

  always #5 clk = ~clk;

  iir_biquad_mc #(
    .CHANNELS   (CH),
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .COEFF_SCALE(CS),
    .COUNT_BITS (CB),
    .ACC_WIDTH  (DW + CW + 3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .div      (div),
    .A2       (A2),
    .A3       (A3),
    .B1       (B1),
    .B2       (B2),
    .B3       (B3),
    .in       (in_bus),
    .out      (out_bus),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] dut_out(input int c);
    logic signed [DW-1:0] s;
    s = out_bus[c*DW +: DW];
    return 64'(s);
  endfunction

  function automatic longint narrow(input longint v);
    longint lim;
    lim = longint'(1) <<< (DW - 1);
`ifdef IIR_BIQUAD_SATURATE_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    begin
      longint low;
      low = v & (lim - 1);
      return (v < 0) ? (low - lim) : low;
    end
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      hx0[c] = 0; hx1[c] = 0; hx2[c] = 0; hy1[c] = 0; hy2[c] = 0; expv[c] = 0;
    end
  endtask

  task automatic model_frame();
    longint b1, b2, b3, a2, a3, s, y;
    b1 = longint'($signed(B1)); b2 = longint'($signed(B2)); b3 = longint'($signed(B3));
    a2 = longint'($signed(A2)); a3 = longint'($signed(A3));
    for (int c = 0; c < CH; c++) begin
      hx2[c] = hx1[c];
      hx1[c] = hx0[c];
      hx0[c] = cur_in[c];
      s = b1*hx0[c] + b2*hx1[c] + b3*hx2[c] - a2*hy1[c] - a3*hy2[c] + (longint'(1) <<< (CS - 1));
      y = narrow(s >>> CS);
      hy2[c] = hy1[c];
      hy1[c] = y;
      expv[c] = y;
    end
  endtask

  task automatic set_in(input longint a, input longint b);
    cur_in[0] = a;
    cur_in[1] = b;
    in_bus = {DW'(b), DW'(a)};
  endtask

  task automatic set_coef(input longint a2, input longint a3, input longint b1, input longint b2, input longint b3);
    A2 = CW'(a2); A3 = CW'(a3); B1 = CW'(b1); B2 = CW'(b2); B3 = CW'(b3);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < budget);
    if (out_valid !== 1'b1) check("valid_timeout", 64'(out_valid), 1);
  endtask

  task automatic check_outs(input string tag);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s_ch%0d", tag, c), dut_out(c), expv[c]);
    end
  endtask

  task automatic run_frame(input string tag, input int exp_period);
    int n;
    wait_valid(2000, n);
    if (exp_period > 0) check({tag, "_period"}, n, exp_period);
    model_frame();
    check_outs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 64'(out_bus), 0);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_overrun", 64'(overrun), 0);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    longint d;

    // Identity filter, first-frame latency and pulse width
    reset = 1'b0;
    div = CB'(20);
    set_coef(0, 0, 16384, 0, 0);
    set_in(1234, -567);
    do_reset();
    wait_valid(200, n);
    check("id_latency", n, 20 + 13);
    model_frame();
    check("id_lit_ch0", dut_out(0), 1234);
    check("id_lit_ch1", dut_out(1), -567);
    @(negedge clk);
    check("id_pulse_drop", 64'(out_valid), 0);
    run_frame("id", 0);
    run_frame("id", 20);

    // Random coefficients and inputs, changed between frames
    for (int f = 0; f < 30; f++) begin
      set_coef(longint'($signed(CW'($urandom))), longint'($signed(CW'($urandom))),
               longint'($signed(CW'($urandom))), longint'($signed(CW'($urandom))),
               longint'($signed(CW'($urandom))));
      set_in(longint'($signed(DW'($urandom))), longint'($signed(DW'($urandom))));
      run_frame("rnd", 20);
    end

    // Lowpass step response from clean history
    set_coef(-18174, 6523, 1183, 2367, 1183);
    set_in(10000, 0);
    do_reset();
    for (int f = 0; f < 40; f++) run_frame("lp", (f == 0) ? 0 : 20);
    d = dut_out(0) - 10000;
    check("lp_settle", 64'((d <= 2) && (d >= -2)), 1);
    check("lp_ch1_zero", dut_out(1), 0);

    // Overflow narrowing
    set_coef(0, 0, 65536, 0, 0);
    set_in(16000, -16000);
    run_frame("sat", 20);
`ifdef IIR_BIQUAD_SATURATE_EN
    check("sat_lit_ch0", dut_out(0), 32767);
    check("sat_lit_ch1", dut_out(1), -32768);
`else
    check("sat_lit_ch0", dut_out(0), 31232);
    check("sat_lit_ch1", dut_out(1), -31232);
`endif

    // Reset during ch1 MAC step 2, then history must be empty
    set_coef(8192, 0, 16384, 16384, 0);
    set_in(700, -900);
    run_frame("pre_rst", 20);
    set_in(-1500, 2500);
    run_frame("pre_rst", 20);
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_out", 64'(out_bus), 0);
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_overrun", 64'(overrun), 0);
    model_reset();
    set_in(321, -4321);
    @(negedge clk);
    reset = 1'b1;
    wait_valid(200, n);
    check("post_rst_latency", n, 20 + 13);
    model_frame();
    check_outs("post_rst");
    check("post_rst_lit_ch0", dut_out(0), 321);
    check("post_rst_lit_ch1", dut_out(1), -4321);

    // Ticks faster than a frame: overrun and dropped ticks
    div = CB'(5);
    set_coef(longint'($signed(CW'($urandom_range(0, 8000)))), 0,
             longint'($signed(CW'($urandom_range(0, 20000)))), 3000, -2000);
    set_in(longint'($signed(DW'($urandom))), longint'($signed(DW'($urandom))));
    do_reset();
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("ovr_before", 64'(overrun), 0);
    @(posedge clk);
    #1;
    check("ovr_second_tick", 64'(overrun), 1);
    run_frame("ovr", 0);
    for (int f = 0; f < 4; f++) begin
      set_in(longint'($signed(DW'($urandom))), longint'($signed(DW'($urandom))));
      run_frame("ovr", 15);
    end
    check("ovr_sticky", 64'(overrun), 1);

    // Divider wrap at div=0
    div = '0;
    set_coef(0, 0, 16384, 0, 0);
    set_in(-2222, 3333);
    do_reset();
    wait_valid(1200, n);
    check("wrap_latency", n, 1024 + 13);
    model_frame();
    check_outs("wrap");
    run_frame("wrap", 1024);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
